// File: rtl/kalman_filter_sm.sv
// kalman_filter_sm: scalar Kalman filter for the FOG sensor path.
// A free-running 22-cycle pass samples z/Q/R, predicts P, finds the gain K with a
// 17-step restoring divide, then updates the Q16.16 estimate x and the covariance P.
// Build option: define KALMAN_VALID_EN to add the o_valid output strobe.
module kalman_filter_sm #(
    parameter int unsigned MEAS_W  = 14,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned DIV_CYC = 17
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic signed [MEAS_W-1:0] i_meas,
    input  logic        [31:0]       i_kal_Q,
    input  logic        [31:0]       i_kal_R,
    output logic signed [31:0]       x_out,
    output logic signed [31:0]       p_out
`ifdef KALMAN_VALID_EN
    ,
    output logic                     o_valid
`endif
);

    localparam int unsigned EW = 33;            // innovation width
    localparam int unsigned MW = DIV_CYC + EW;  // K * e product width
    localparam int unsigned NW = DIV_CYC + 32;  // K * Pp product width
    localparam int unsigned CW = $clog2(DIV_CYC);

    localparam logic [2:0] S_SAMPLE  = 3'd0;
    localparam logic [2:0] S_PREDICT = 3'd1;
    localparam logic [2:0] S_DIV     = 3'd2;
    localparam logic [2:0] S_MUL     = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam logic signed [MW-1:0] RND_HALF = MW'(1) <<< (FRAC_W - 1);

    logic [2:0]               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [MEAS_W-1:0] z_q, z_d;
    logic [31:0]              q_q, q_d, r_q, r_d;
    logic [31:0]              pp_q, pp_d;
    logic [32:0]              d_q, d_d;
    logic [33:0]              rem_q, rem_d;
    logic [DIV_CYC-1:0]       k_q, k_d;
    logic signed [MW-1:0]     m_q, m_d;
    logic [NW-1:0]            n_q, n_d;
    logic signed [31:0]       x_q, x_d, p_q, p_d;
    logic signed [31:0]       xo_q, xo_d, po_q, po_d;

    // Predict: Pp = P + Q saturated to the positive 32-bit range, D = Pp + R.
    logic [32:0] pp_sum, d_sum;
    logic [31:0] pp_sat;
    assign pp_sum = {1'b0, p_q} + {1'b0, q_q};
    assign pp_sat = (pp_sum > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : pp_sum[31:0];
    assign d_sum  = {1'b0, pp_sat} + {1'b0, r_q};

    // Divide step: remainder starts at Pp, so the first compare yields the 2^16 bit.
    // D == 0 forces every quotient bit low, giving K = 0.
    logic        div_ge;
    logic [33:0] div_rem;
    assign div_ge  = (d_q != '0) && (rem_q >= {1'b0, d_q});
    assign div_rem = div_ge ? (rem_q - {1'b0, d_q}) : rem_q;

    // Innovation e = (z <<< 16) - x, widened operands for the signed K * e product.
    logic signed [EW-1:0] z_ext, x_ext, err;
    logic signed [MW-1:0] k_mx, e_mx;
    assign z_ext = {{(EW-MEAS_W-FRAC_W){z_q[MEAS_W-1]}}, z_q, {FRAC_W{1'b0}}};
    assign x_ext = {x_q[31], x_q};
    assign err   = z_ext - x_ext;
    assign k_mx  = {{(MW-DIV_CYC){1'b0}}, k_q};
    assign e_mx  = {{(MW-EW){err[EW-1]}}, err};

    // Update: round-half-up the correction, saturate x; P = Pp - (n >> 16) floored at 0.
    logic signed [MW-1:0] m_rnd, delta, x_sum;
    logic                 x_ovf;
    logic signed [31:0]   x_sat, p_new;
    logic [NW-1:0]        n_sh;
    assign m_rnd = m_q + RND_HALF;
    assign delta = m_rnd >>> FRAC_W;
    assign x_sum = {{(MW-32){x_q[31]}}, x_q} + delta;
    assign x_ovf = (x_sum[MW-1:31] != {(MW-31){x_sum[MW-1]}});
    assign x_sat = x_ovf ? (x_sum[MW-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : x_sum[31:0];
    assign n_sh  = n_q >> FRAC_W;
    assign p_new = (n_sh > {{(NW-32){1'b0}}, pp_q}) ? '0 : (pp_q - n_sh[31:0]);

    // Sequencer and per-state next-state values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        q_d     = q_q;
        r_d     = r_q;
        pp_d    = pp_q;
        d_d     = d_q;
        rem_d   = rem_q;
        k_d     = k_q;
        m_d     = m_q;
        n_d     = n_q;
        x_d     = x_q;
        p_d     = p_q;
        xo_d    = xo_q;
        po_d    = po_q;
        case (state_q)
            S_SAMPLE: begin
                z_d     = i_meas;
                q_d     = i_kal_Q;
                r_d     = i_kal_R;
                state_d = S_PREDICT;
            end
            S_PREDICT: begin
                pp_d    = pp_sat;
                d_d     = d_sum;
                rem_d   = {2'b00, pp_sat};
                k_d     = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = div_rem << 1;
                k_d   = {k_q[DIV_CYC-2:0], div_ge};
                if (cnt_q == CW'(DIV_CYC - 1)) begin
                    state_d = S_MUL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MUL: begin
                m_d     = k_mx * e_mx;
                n_d     = {{(NW-DIV_CYC){1'b0}}, k_q} * {{(NW-32){1'b0}}, pp_q};
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                x_d     = x_sat;
                p_d     = p_new;
                state_d = S_OUT;
            end
            S_OUT: begin
                xo_d    = x_q;
                po_d    = p_q;
                state_d = S_SAMPLE;
            end
            default: state_d = S_SAMPLE;
        endcase
    end

    // State registers; reset abandons any pass in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_SAMPLE;
            cnt_q   <= '0;
            z_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            pp_q    <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            p_q     <= '0;
            xo_q    <= '0;
            po_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            q_q     <= q_d;
            r_q     <= r_d;
            pp_q    <= pp_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            x_q     <= x_d;
            p_q     <= p_d;
            xo_q    <= xo_d;
            po_q    <= po_d;
        end
    end

    assign x_out = xo_q;
    assign p_out = po_q;

`ifdef KALMAN_VALID_EN
    logic valid_q;

    // One-cycle strobe in the cycle right after x_out/p_out load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == S_OUT);
        end
    end

    assign o_valid = valid_q;
`endif

endmodule

// File: tb/tb_kalman_filter_sm.sv
// tb_kalman_filter_sm: directed bench for kalman_filter_sm with a per-cycle
// arithmetic reference model plus hand-computed anchor values.
// Build option: KALMAN_VALID_EN also checks the o_valid strobe.
module tb_kalman_filter_sm;

    logic               clk;
    logic               rst;
    logic signed [13:0] meas;
    logic [31:0]        kq;
    logic [31:0]        kr;
    logic signed [31:0] x_out;
    logic signed [31:0] p_out;
`ifdef KALMAN_VALID_EN
    logic               valid;
`endif

    int total;
    int bad;
    bit armed;

    // Reference state: outputs expected after each completed pass
    longint ex;
    longint ep;
    bit     ev;

    kalman_filter_sm dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_meas  (meas),
        .i_kal_Q (kq),
        .i_kal_R (kr),
        .x_out   (x_out),
        .p_out   (p_out)
`ifdef KALMAN_VALID_EN
        ,
        .o_valid (valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: one filter pass per 22 clocks, inputs taken on the first clock
    initial begin
        int     cyc;
        longint mx, mp, lz, lq, lr;
        longint pp, d, k, e, dl, n;
        cyc = 0; mx = 0; mp = 0; lz = 0; lq = 0; lr = 0;
        ex = 0; ep = 0; ev = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc = 0; mx = 0; mp = 0;
                ex = 0; ep = 0; ev = 1'b0;
            end else begin
                cyc++;
                ev = 1'b0;
                if (cyc % 22 == 1) begin
                    lz = meas;
                    lq = kq;
                    lr = kr;
                end
                if (cyc % 22 == 0) begin
                    pp = mp + lq;
                    if (pp > 2147483647) pp = 2147483647;
                    d  = pp + lr;
                    k  = (d == 0) ? 0 : (pp * 65536) / d;
                    e  = lz * 65536 - mx;
                    dl = (k * e + 32768) >>> 16;
                    mx = mx + dl;
                    if (mx > 2147483647) mx = 2147483647;
                    if (mx < -64'sd2147483648) mx = -64'sd2147483648;
                    n  = k * pp;
                    mp = pp - (n >>> 16);
                    if (mp < 0) mp = 0;
                    ex = mx;
                    ep = mp;
                    ev = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check("model_x", x_out, ex);
                check("model_p", p_out, ep);
`ifdef KALMAN_VALID_EN
                check("model_valid", longint'(valid), longint'(ev));
`endif
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        longint             diff;
        int                 last_chg;
        logic signed [31:0] prev_x;
        total = 0; bad = 0; armed = 1'b0;
        rst = 1'b1; meas = 14'sd1000; kq = 32'd1; kr = 32'd100;

        // Reset for 5 clocks, then first update exactly 22 clocks after release
        repeat (5) @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        check("reset_x", x_out, 0);
        check("reset_p", p_out, 0);
        rst = 1'b0;
        repeat (21) @(negedge clk);
        check("pre_first_x", x_out, 0);
        @(negedge clk);
        check("first_x", x_out, 648000);
        check("first_p", p_out, 1);

        // Constant 1000, Q=1, R=100: P settles at 10, x creeps up to just below 1000<<16
        repeat (22 * 19) @(negedge clk);
        check("steady_p20", p_out, 10);
        repeat (22 * 380) @(negedge clk);
        check("steady_p400", p_out, 10);
        diff = longint'(x_out) - 65536000;
        total++;
        if (diff > 8 || diff < -8) begin
            bad++;
            $display("FAIL settle_x: got %0d, want 65536000 +-8", x_out);
        end

        // Q=R=0: divisor is zero, gain forced to 0, nothing moves
        meas = 14'sd500; kq = 32'd0; kr = 32'd0;
        pulse_reset();
        repeat (22 * 5) @(negedge clk);
        check("zero_qr_x", x_out, 0);
        check("zero_qr_p", p_out, 0);

        // Huge Q: Pp saturates, K = 65535, x lands on -8192<<16 in two passes
        meas = -14'sd8192; kq = 32'hFFFF_FFFF; kr = 32'd1;
        pulse_reset();
        repeat (22) @(negedge clk);
        check("bigq_x1", x_out, -536862720);
        check("bigq_p1", p_out, 32768);
        repeat (22) @(negedge clk);
        check("bigq_x2", x_out, -536870912);
        check("bigq_p2", p_out, 32768);
        repeat (22 * 3) @(negedge clk);
        check("bigq_p5", p_out, 32768);

        // Wrapping ramp: inputs change every clock, updates must stay 22 clocks apart
        kq = 32'd1; kr = 32'd100;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        meas = 14'sd13;
        last_chg = -1;
        prev_x = x_out;
        for (int i = 1; i <= 22 * 60; i++) begin
            @(negedge clk);
            meas = 14'(i * 13 + 13);
            if (x_out != prev_x) begin
                if (last_chg >= 0) check("ramp_period", i - last_chg, 22);
                last_chg = i;
                prev_x   = x_out;
            end
        end

        // Reset while dividing: outputs clear next clock, restart is clean
        meas = 14'sd1000; kq = 32'd1; kr = 32'd100;
        pulse_reset();
        repeat (22 * 3 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_x", x_out, 0);
        check("abort_p", p_out, 0);
        rst = 1'b0;
        repeat (21) @(negedge clk);
        check("restart_pre_x", x_out, 0);
        @(negedge clk);
        check("restart_x", x_out, 648000);
        check("restart_p", p_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
